// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared MDU op encodings, latency defaults and op-class helpers
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } mdu_op_e;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_start_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || is_div_op(op);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - combinational multiply/divide datapath producing HI/LO results
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div0
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] quo;
    logic [31:0] rem;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Divide on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
    assign a_neg   = (op == OP_DIV) & a[31];
    assign b_neg   = (op == OP_DIV) & b[31];
    assign mag_a   = a_neg ? (32'd0 - a) : a;
    assign mag_b   = b_neg ? (32'd0 - b) : b;
    assign div0    = (b == 32'd0);
    assign divisor = div0 ? 32'd1 : mag_b;
    assign quo     = mag_a / divisor;
    assign rem     = mag_a % divisor;

    always_comb begin
        hi_res = 32'd0;
        lo_res = 32'd0;
        case (op)
            OP_MULT:  {hi_res, lo_res} = prod_s;
            OP_MULTU: {hi_res, lo_res} = prod_u;
            OP_DIV, OP_DIVU: begin
                hi_res = a_neg ? (32'd0 - rem) : rem;
                lo_res = (a_neg ^ b_neg) ? (32'd0 - quo) : quo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle MDU: busy counter, shadow result and architectural HI/LO
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        start,
    output logic        busy,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
    logic          sh_div0_q, sh_div0_d;
    logic [3:0]    op_q, op_d;
    logic [31:0]   calc_hi, calc_lo;
    logic          calc_div0;
    logic          idle_valid;

    mdu_calc u_calc (
        .a      (a),
        .b      (b),
        .op     (op),
        .hi_res (calc_hi),
        .lo_res (calc_lo),
        .div0   (calc_div0)
    );

    assign busy       = (cnt_q != '0);
    assign idle_valid = op_valid & ~busy;
    assign start      = idle_valid & is_start_op(op);

    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        sh_hi_d   = sh_hi_q;
        sh_lo_d   = sh_lo_q;
        sh_div0_d = sh_div0_q;
        op_d      = op_q;
        if (start) begin
            sh_hi_d   = calc_hi;
            sh_lo_d   = calc_lo;
            sh_div0_d = calc_div0;
            op_d      = op;
            cnt_d     = is_div_op(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (busy) begin
            cnt_d = cnt_q - CW'(1);
            // A divide by zero still burns its cycles but never commits.
            if (cnt_q == CW'(1) && !(is_div_op(op_q) && sh_div0_q)) begin
                hi_d = sh_hi_q;
                lo_d = sh_lo_q;
            end
        end
        if (idle_valid && op == OP_MTHI) hi_d = a;
        if (idle_valid && op == OP_MTLO) lo_d = a;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            sh_hi_q   <= 32'd0;
            sh_lo_q   <= 32'd0;
            sh_div0_q <= 1'b0;
            op_q      <= 4'd0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            sh_hi_q   <= sh_hi_d;
            sh_lo_q   <= sh_lo_d;
            sh_div0_q <= sh_div0_d;
            op_q      <= op_d;
        end
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign rd_data = (op == OP_MFHI) ? hi_q : (op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration of MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10, busy duration of DIV/DIVU.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset, with ports as follows.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-low reset (0 = reset).
REQ-004 op_valid  in  1  E-stage instruction is an MDU op this cycle.
REQ-005 op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO.
REQ-006 a  in  32  forwarded rs operand from E stage.
REQ-007 b  in  32  forwarded rt operand from E stage.
REQ-008 start  out  1  combinational; op_valid & op in {1..4} & ~busy.
REQ-009 busy  out  1  registered; operation in flight.
REQ-010 rd_data  out  32  combinational; HI when op=MFHI, LO when op=MFLO, else 0.
REQ-011 hi, lo  out  32 each  architectural HI/LO registers.

Function
REQ-012 Accept: on the edge where start=1, latch the result of a,b and the op into shadow registers and load the counter with MULT_CYCLES or DIV_CYCLES.
REQ-013 busy SHALL equal (counter != 0), so it is high for exactly N cycles after the accept edge.
REQ-014 On the edge where the counter goes 1->0, the shadow result SHALL be written to HI/LO, and busy SHALL drop in the same cycle that the new HI/LO become visible.
REQ-015 MULT: signed 64-bit product; HI = [63:32], LO = [31:0]. MULTU: the same, unsigned.
REQ-016 DIV: signed; LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
REQ-017 DIVU: unsigned; LO = quotient, HI = remainder.
REQ-018 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO = 0x80000000, HI = 0.
REQ-019 Divide by zero (b = 0) SHALL still busy for DIV_CYCLES and SHALL leave HI/LO unchanged at completion.
REQ-020 MTHI/MTLO with op_valid & ~busy SHALL write a to HI/LO at the next edge; there is no busy.
REQ-021 Any op_valid while busy=1 (including MTHI/MTLO and a new start) SHALL be ignored. The hazard unit SHALL hold the D stage on any MDU instruction while busy|start, so no accepted op is lost.
REQ-022 MFHI/MFLO SHALL return the current register value with no side effect.
REQ-023 op values 0 and 9..15, or op_valid = 0, SHALL have no effect.
REQ-024 Completion edge coinciding with op_valid: the op is ignored because busy=1 in that cycle.

Reset
REQ-025 While reset = 0 at a rising edge: HI, LO, counter, shadow registers and the latched op SHALL be cleared to 0.
REQ-026 After reset: busy = 0, start follows its inputs, and rd_data reads 0.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no HI/LO commit.

Structure
REQ-028 Op encodings, MULT_CYCLES and DIV_CYCLES defaults SHALL live in the shared CPU definitions header, shared with ctrl and the hazard unit.
REQ-029 The arithmetic SHALL live in one combinational sub-module, mdu_calc (inputs a, b, op; outputs hi_res, lo_res, div0). The counter, shadow registers and HI/LO SHALL stay in mdu.

Verification
REQ-030 MULT a=0xFFFFFFFF, b=2 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-031 MULTU a=0xFFFFFFFF, b=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles; MFHI then gives rd_data=0x00000001.
REQ-032 DIV a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU with the same operands -> LO=0x7FFFFFFC, HI=0x00000001.
REQ-033 MTLO a=0x12345678, then DIV with b=0 -> busy 10 cycles, then LO remains 0x12345678.
REQ-034 MULT accepted, MTHI 0xAAAA issued on busy cycle 3 -> MTHI ignored; HI = product high word.
REQ-035 DIV accepted, reset=0 on busy cycle 4 -> next cycle busy=0, HI=LO=0, and no later commit.
